alu_issue_stage: RTL and testbench

- ID/EX pipeline stage that produces the ALU's input interface.
- Decodes a registered RV32I integer instruction into an alu_op_e Opcode (from control_pkg).
- Selects the A/B operands (register, PC, immediate) and holds them in a valid/ready pipeline register.
- Flags illegal encodings and supports pipeline stall and flush.

---
 rtl/alu_issue_stage.sv | 166 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// ID/EX stage: decodes RV32I integer ops into ALU operands and opcode,
// held in a valid/ready pipeline register with stall and flush.
package control_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;
endpackage

module alu_issue_stage
    import control_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    input  logic [XLEN-1:0]       pc,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       A,
    output logic [XLEN-1:0]       B,
    output alu_op_e               Opcode,
    output logic [REG_ADDR_W-1:0] rd,
    output logic                  wb_en,
    output logic                  illegal
);

    logic                  r_valid;
    logic [XLEN-1:0]       r_a;
    logic [XLEN-1:0]       r_b;
    alu_op_e               r_op;
    logic [REG_ADDR_W-1:0] r_rd;
    logic                  r_ill;

    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    alu_op_e         w_op;
    logic            w_ill;
    logic            w_accept;
    logic [XLEN-1:0] w_immi;
    logic [XLEN-1:0] w_immu;
    logic [2:0]      w_f3;
    logic            w_f7_zero;
    logic            w_f7_alt;
    logic            w_is_op;
    logic            w_is_imm;
    logic            w_is_lui;
    logic            w_is_auipc;

    function automatic alu_op_e f3_op(input logic [2:0] f3);
        alu_op_e op;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    assign w_immi     = XLEN'($signed(instr[31:20]));
    assign w_immu     = XLEN'($signed({instr[31:12], 12'b0}));
    assign w_f3       = instr[14:12];
    assign w_f7_zero  = (instr[31:25] == 7'b0000000);
    assign w_f7_alt   = (instr[31:25] == 7'b0100000);
    assign w_is_op    = (instr[6:0] == 7'b0110011);
    assign w_is_imm   = (instr[6:0] == 7'b0010011);
    assign w_is_lui   = (instr[6:0] == 7'b0110111);
    assign w_is_auipc = (instr[6:0] == 7'b0010111);

    always_comb begin
        w_a   = '0;
        w_b   = '0;
        w_op  = ALU_ADD;
        w_ill = 1'b0;
        unique case (1'b1)
            w_is_op: begin
                w_a = rs1_data;
                w_b = rs2_data;
                unique case (1'b1)
                    w_f7_zero:                       w_op = f3_op(w_f3);
                    w_f7_alt && (w_f3 == 3'b000):    w_op = ALU_SUB;
                    w_f7_alt && (w_f3 == 3'b101):    w_op = ALU_SRA;
                    default:                         w_ill = 1'b1;
                endcase
            end
            w_is_imm: begin
                w_a  = rs1_data;
                w_b  = w_immi;
                w_op = f3_op(w_f3);
                // Shift immediates reuse instr[31:25] as a funct7 qualifier
                if (w_f3 == 3'b001 && !w_f7_zero) begin
                    w_ill = 1'b1;
                end
                if (w_f3 == 3'b101) begin
                    if (w_f7_alt) begin
                        w_op = ALU_SRA;
                    end else if (!w_f7_zero) begin
                        w_ill = 1'b1;
                    end
                end
            end
            w_is_lui: begin
                w_b = w_immu;
            end
            w_is_auipc: begin
                w_a = pc;
                w_b = w_immu;
            end
            default: w_ill = 1'b1;
        endcase
    end

    assign in_ready = ~r_valid | out_ready;
    assign w_accept = in_valid & in_ready & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= ALU_ADD;
            r_rd    <= '0;
            r_ill   <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_a     <= w_a;
            r_b     <= w_b;
            r_op    <= w_op;
            r_rd    <= REG_ADDR_W'(instr[11:7]);
            r_ill   <= w_ill;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign A         = r_a;
    assign B         = r_b;
    assign Opcode    = r_op;
    assign rd        = r_rd;
    assign illegal   = r_valid & r_ill;
    assign wb_en     = r_valid & ~r_ill & (r_rd != '0);

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: queue-based reference model checked every
// cycle, plus directed vectors with hand-computed expectations.
module tb_alu_issue_stage;
    import control_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] A;
    logic [31:0] B;
    alu_op_e     Opcode;
    logic [4:0]  rd;
    logic        wb_en;
    logic        illegal;

    int checks   = 0;
    int failures = 0;

    alu_issue_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .A(A), .B(B), .Opcode(Opcode), .rd(rd),
        .wb_en(wb_en), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        alu_op_e     op;
        logic [4:0]  rd;
        logic        ill;
        logic        dc;
    } exp_t;

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p,
                                   input logic [31:0] r1, input logic [31:0] r2);
        alu_op_e base [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                              ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        exp_t e;
        int opc = int'(ins[6:0]);
        int f3  = int'(ins[14:12]);
        int f7  = int'(ins[31:25]);
        e.a = 0; e.b = 0; e.op = ALU_ADD; e.rd = ins[11:7]; e.ill = 0; e.dc = 0;
        if (opc == 'h33) begin
            e.a = r1; e.b = r2;
            if (f7 == 0) e.op = base[f3];
            else if (f7 == 'h20 && f3 == 0) e.op = ALU_SUB;
            else if (f7 == 'h20 && f3 == 5) e.op = ALU_SRA;
            else begin e.ill = 1; e.dc = 1; end
        end else if (opc == 'h13) begin
            e.a = r1;
            e.b = {{20{ins[31]}}, ins[31:20]};
            e.op = base[f3];
            if (f3 == 1 && f7 != 0) begin e.ill = 1; e.dc = 1; end
            if (f3 == 5 && f7 == 'h20) e.op = ALU_SRA;
            else if (f3 == 5 && f7 != 0) begin e.ill = 1; e.dc = 1; end
        end else if (opc == 'h37) begin
            e.b = {ins[31:12], 12'h000};
        end else if (opc == 'h17) begin
            e.a = p;
            e.b = {ins[31:12], 12'h000};
        end else begin
            e.ill = 1;
        end
        return e;
    endfunction

    exp_t q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else if (flush) begin
            q.delete();
        end else begin
            automatic bit acc = in_valid && (q.size() == 0 || out_ready);
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (acc) q.push_back(model(instr, pc, rs1_data, rs2_data));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m_in_ready", 32'(in_ready), 32'(q.size() == 0 || out_ready));
        chk("m_out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("m_rd", 32'(rd), 32'(q[0].rd));
            chk("m_illegal", 32'(illegal), 32'(q[0].ill));
            chk("m_wb_en", 32'(wb_en), 32'(!q[0].ill && q[0].rd != 0));
            if (!q[0].dc) begin
                chk("m_A", A, q[0].a);
                chk("m_B", B, q[0].b);
                chk("m_op", 32'(Opcode), 32'(q[0].op));
            end
        end else begin
            chk("m_wb_idle", 32'(wb_en), 32'(0));
        end
    end

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic ordy, input logic fl);
        in_valid = v; instr = ins; pc = p; rs1_data = r1; rs2_data = r2;
        out_ready = ordy; flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'(0));
        chk({tag, "_A"}, A, 32'h0);
        chk({tag, "_B"}, B, 32'h0);
        chk({tag, "_op"}, 32'(Opcode), 32'(ALU_ADD));
        chk({tag, "_rd"}, 32'(rd), 32'(0));
        chk({tag, "_ill"}, 32'(illegal), 32'(0));
        chk({tag, "_wb"}, 32'(wb_en), 32'(0));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(1));
    endtask

    logic [31:0] vec [12] = '{
        32'h0020E1B3, 32'h0020F1B3, 32'h0020A1B3, 32'h0020B1B3,
        32'h0020C1B3, 32'h0020D1B3, 32'h4020D1B3, 32'h002091B3,
        32'h0220_81B3, 32'hFFF0C193, 32'h0030B193, 32'h0000D093
    };

    initial begin
        rst = 1'b1;
        drive(0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_reset_vals("rst_init");

        drive(1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1, 0);
        tick();
        chk("add_valid", 32'(out_valid), 32'(1));
        chk("add_A", A, 32'd5);
        chk("add_B", B, 32'd7);
        chk("add_op", 32'(Opcode), 32'(ALU_ADD));
        chk("add_rd", 32'(rd), 32'd3);
        chk("add_wb", 32'(wb_en), 32'(1));

        drive(1, 32'h402081B3, 32'h0, 32'd9, 32'd4, 1, 0);
        tick();
        chk("sub_valid", 32'(out_valid), 32'(1));
        chk("sub_op", 32'(Opcode), 32'(ALU_SUB));
        chk("sub_A", A, 32'd9);
        chk("sub_B", B, 32'd4);

        drive(1, 32'hFFF00093, 32'h0, 32'h0, 32'h0, 1, 0);
        tick();
        chk("addi_B", B, 32'hFFFFFFFF);
        chk("addi_op", 32'(Opcode), 32'(ALU_ADD));
        chk("addi_rd", 32'(rd), 32'd1);

        drive(1, 32'h4040D093, 32'h0, 32'h80000000, 32'h0, 1, 0);
        tick();
        chk("srai_op", 32'(Opcode), 32'(ALU_SRA));
        chk("srai_shamt", 32'(B[4:0]), 32'd4);
        chk("srai_B", B, 32'h00000404);

        drive(1, 32'h40309093, 32'h0, 32'h1, 32'h0, 1, 0);
        tick();
        chk("slli_bad_valid", 32'(out_valid), 32'(1));
        chk("slli_bad_ill", 32'(illegal), 32'(1));
        chk("slli_bad_wb", 32'(wb_en), 32'(0));

        drive(1, 32'h123452B7, 32'h40, 32'hDEAD, 32'hBEEF, 1, 0);
        tick();
        chk("lui_A", A, 32'h0);
        chk("lui_B", B, 32'h12345000);
        chk("lui_rd", 32'(rd), 32'd5);

        drive(1, 32'h00001317, 32'h100, 32'h55, 32'h66, 1, 0);
        tick();
        chk("auipc_A", A, 32'h100);
        chk("auipc_B", B, 32'h1000);
        chk("auipc_op", 32'(Opcode), 32'(ALU_ADD));

        for (int i = 0; i < 12; i++) begin
            drive(1, vec[i], 32'h0, $urandom, $urandom, 1, 0);
            tick();
        end

        drive(1, 32'h002081B3, 32'h0, 32'd11, 32'd22, 1, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h0020C1B3, 32'h0, 32'd99, 32'd88, 0, i == 2);
            #1;
            chk("stall_in_ready", 32'(in_ready), 32'(0));
            chk("stall_A", A, 32'd11);
            chk("stall_B", B, 32'd22);
            chk("stall_op", 32'(Opcode), 32'(ALU_ADD));
            if (i < 2) begin
                tick();
                chk("stall_valid", 32'(out_valid), 32'(1));
            end else begin
                @(posedge clk);
                #1;
            end
        end
        chk("flush_valid", 32'(out_valid), 32'(0));
        chk("flush_wb", 32'(wb_en), 32'(0));
        drive(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);
        tick();
        chk("flush_no_accept", 32'(out_valid), 32'(0));

        drive(1, 32'h002081B3, 32'h0, 32'd1, 32'd2, 1, 0);
        tick();
        drive(1, 32'h402081B3, 32'h0, 32'd3, 32'd4, 1, 1);
        tick();
        chk("flush_rdy_valid", 32'(out_valid), 32'(0));

        drive(1, 32'h002081B3, 32'h0, 32'd1, 32'd2, 1, 0);
        tick();
        drive(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);
        tick();
        chk("consume_valid", 32'(out_valid), 32'(0));

        drive(1, 32'h0000007F, 32'h0, 32'h7, 32'h8, 1, 0);
        tick();
        chk("bad_opc_valid", 32'(out_valid), 32'(1));
        chk("bad_opc_ill", 32'(illegal), 32'(1));
        chk("bad_opc_wb", 32'(wb_en), 32'(0));
        chk("bad_opc_A", A, 32'h0);
        chk("bad_opc_B", B, 32'h0);

        drive(1, 32'h00208033, 32'h0, 32'h7, 32'h8, 1, 0);
        tick();
        chk("x0_valid", 32'(out_valid), 32'(1));
        chk("x0_ill", 32'(illegal), 32'(0));
        chk("x0_wb", 32'(wb_en), 32'(0));

        drive(1, 32'h002081B3, 32'h0, 32'h31, 32'h42, 1, 0);
        tick();
        drive(1, 32'h402081B3, 32'h0, 32'h1, 32'h1, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("rst_async");
        @(posedge clk);
        #1 rst = 1'b0;
        chk("post_rst_in_ready", 32'(in_ready), 32'(1));
        drive(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);
        tick();
        chk("post_rst_valid", 32'(out_valid), 32'(0));

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
